lif_neuron: RTL and testbench
=============================

// Module: lif_neuron
// PURPOSE
//  Leaky integrate-and-fire neuron core: sums signed synaptic weights of active input spikes into a
//  membrane state value, applies periodic shift-leak, emits a one-cycle spike on threshold crossing,
//  then enforces a refractory period. Sits directly upstream of the last-value register:
//  o_spike drives its capture edge and o_sv its data.
// PARAMETERS
//  p_width        20  membrane/state width, unsigned, saturating
//  p_n_syn         8  number of synaptic inputs
//  p_wwidth        8  per-synapse weight width, two's complement
//  p_leak_period  16  enabled cycles between leak events; 0 = leak disabled
//  p_leak_shift    4  leak amount = r_sv >> p_leak_shift
//  p_refrac        4  refractory length in cycles after the spike cycle; 0 allowed
// PORTS
//  i_clk        in   1                 clock, all state on rising edge
//  i_rst        in   1                 asynchronous, active-high reset
//  i_en         in   1                 integration/leak enable
//  i_syn_spike  in   p_n_syn           synapse k active when bit k = 1
//  i_weights    in   p_n_syn*p_wwidth  weight k at [k*p_wwidth +: p_wwidth], signed
//  i_threshold  in   p_width           firing threshold, unsigned
//  o_sv         out  p_width           membrane state value (registered)
//  o_spike      out  1                 spike pulse, high exactly one cycle per fire
//  o_refractory out  1                 high while in REFRACTORY
// BEHAVIOUR
//  Reset (async, any time): state=INTEGRATE, r_sv=0, leak counter=0, refrac counter=0;
//   o_sv=0, o_spike=0, o_refractory=0. Reset mid-spike or mid-refractory aborts immediately.
//  Outputs are pure register/state decodes: o_spike=(state==FIRE), o_refractory=(state==REFRAC).
//  Syn sum: signed sum of weights with spike bit set; width p_wwidth+clog2(p_n_syn)+1, no overflow.
//  Leak tick: leak counter counts enabled INTEGRATE cycles 0..p_leak_period-1; tick when it equals
//   p_leak_period-1 (then wraps to 0). leak_amt = tick ? r_sv>>p_leak_shift : 0.
//  new = clamp(r_sv - leak_amt + sum) to [0, 2^p_width-1]; signed intermediate, no wrap-around.
//  FSM:
//   INTEGRATE, i_en=0: hold r_sv, leak counter, state.
//   INTEGRATE, i_en=1: r_sv<=new; if new >= i_threshold -> FIRE (r_sv holds peak new), else stay.
//   FIRE (1 cycle, ignores i_en/inputs): o_spike=1, o_sv=peak, stable for the whole cycle;
//    next: r_sv<=0, leak counter<=0; -> REFRAC with counter=p_refrac-1, or INTEGRATE if p_refrac=0.
//   REFRAC: inputs and i_en ignored, r_sv held 0; counter decrements; at 0 -> INTEGRATE.
//  Latency: input spike at edge n is reflected in o_sv after edge n; fire decision at the same edge,
//   so o_spike rises after edge n, falls after edge n+1.
//  i_threshold=0: fires on every enabled INTEGRATE cycle. Threshold change takes effect next compare.
//  Saturated at max and still below threshold: holds max, no wrap.
//  Leak and input on same cycle: both applied in one clamp; leak uses pre-update r_sv.
//  Min spike spacing: 2+p_refrac cycles. o_spike never high two consecutive cycles.
// TESTING
//  1 p_leak_period=0, syn0 weight 10 held active, thr 50: o_sv 10,20,30,40,50; o_spike high on the
//    cycle o_sv=50; then o_sv=0 with o_refractory high 4 cycles; integration resumes, next spike 5 later.
//  2 r_sv=100, syn3 weight -128 (0x80): o_sv=0 (clamped), no spike; all 8 syn at +127, thr 2000:
//    o_sv rises by 1016 per cycle, spike when >=2000 (2nd cycle, peak 2032).
//  3 Leak: r_sv=1600, no input, i_en=1, thr max: after 16 enabled cycles o_sv=1500; i_en=0 for
//    10 cycles in between -> tick delayed by exactly 10 cycles, value unchanged meanwhile.
//  4 Saturation: thr=2^20-1, weights +127 on all synapses until clamp: o_sv stops at 0xFFFFF,
//    no wrap; then spike fires at 0xFFFFF (>=thr) with o_sv=0xFFFFF during spike cycle.
//  5 Reset: assert i_rst during FIRE cycle and separately mid-REFRAC: all outputs 0 asynchronously,
//    state INTEGRATE after release; p_refrac=0 build: spike then integrate next cycle, spacing 2.
//  6 Checker: o_sv stable while o_spike high; downstream capture on o_spike posedge equals peak.

Source files
------------

// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron core.
// Each enabled cycle the signed weights of the active synapses are added to the
// membrane value r_sv, which saturates to [0, 2^p_width-1]. A periodic shift-leak
// is folded into the same clamp. Crossing the threshold gives a one-cycle FIRE
// state, in which o_sv still shows the peak value. A refractory period with r_sv
// held at zero follows the spike.
// There is no valid/ready handshake on this block. i_en only qualifies
// integration and leak. o_spike is a single-cycle strobe that the downstream
// last-value register uses as its capture edge for o_sv.
module lif_neuron #(
    parameter int p_width       = 20,
    parameter int p_n_syn       = 8,
    parameter int p_wwidth      = 8,
    parameter int p_leak_period = 16,
    parameter int p_leak_shift  = 4,
    parameter int p_refrac      = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_en,
    input  logic [p_n_syn-1:0]            i_syn_spike,
    input  logic [p_n_syn*p_wwidth-1:0]   i_weights,
    input  logic [p_width-1:0]            i_threshold,
    output logic [p_width-1:0]            o_sv,
    output logic                          o_spike,
    output logic                          o_refractory,
    output logic [1:0]                    o_dbg_state
);

    // The synapse sum is wide enough that it can never overflow.
    localparam int SW  = p_wwidth + $clog2(p_n_syn) + 1;
    // The update arithmetic carries one extra bit for the sign and one for headroom.
    localparam int NW  = ((p_width > SW) ? p_width : SW) + 2;
    localparam int LCW = (p_leak_period > 1) ? $clog2(p_leak_period) : 1;
    localparam int RCW = (p_refrac > 1) ? $clog2(p_refrac) : 1;

    localparam bit              LEAK_ON     = (p_leak_period > 0);
    localparam bit              REFRAC_ON   = (p_refrac > 0);
    localparam logic [LCW-1:0]  LEAK_LAST   = LCW'((p_leak_period > 0) ? p_leak_period - 1 : 0);
    localparam logic [RCW-1:0]  REFRAC_LOAD = RCW'((p_refrac > 0) ? p_refrac - 1 : 0);
    localparam logic [p_width-1:0] SV_MAX   = '1;
    localparam logic [NW-1:0]   SV_MAX_EXT  = {{(NW-p_width){1'b0}}, SV_MAX};

    typedef enum logic [1:0] {
        ST_INTEGRATE = 2'd0,
        ST_FIRE      = 2'd1,
        ST_REFRAC    = 2'd2
    } state_t;

    state_t             state;
    logic [p_width-1:0] r_sv;
    logic [LCW-1:0]     r_leak_cnt;
    logic [RCW-1:0]     r_refrac_cnt;

    logic [SW-1:0]      syn_sum;
    logic               leak_tick;
    logic [p_width-1:0] leak_amt;
    logic [NW-1:0]      new_full;
    logic [p_width-1:0] new_sv;

    // Two's-complement sum of the weights whose synapse bit is set.
    always_comb begin
        syn_sum = '0;
        for (int k = 0; k < p_n_syn; k++) begin
            if (i_syn_spike[k]) begin
                syn_sum = syn_sum + {{(SW-p_wwidth){i_weights[k*p_wwidth + p_wwidth - 1]}},
                                     i_weights[k*p_wwidth +: p_wwidth]};
            end
        end
    end

    // The leak applies on the last cycle of each period and uses the pre-update membrane value.
    always_comb begin
        leak_tick = LEAK_ON && (r_leak_cnt == LEAK_LAST);
        leak_amt  = leak_tick ? (r_sv >> p_leak_shift) : '0;
    end

    // Leak and input are combined in wide arithmetic, then clamped to [0, max].
    always_comb begin
        new_full = {{(NW-p_width){1'b0}}, r_sv}
                 - {{(NW-p_width){1'b0}}, leak_amt}
                 + {{(NW-SW){syn_sum[SW-1]}}, syn_sum};
        if (new_full[NW-1]) begin
            new_sv = '0;
        end else if (new_full > SV_MAX_EXT) begin
            new_sv = SV_MAX;
        end else begin
            new_sv = new_full[p_width-1:0];
        end
    end

    // Neuron FSM: integrate, then a single fire cycle, then the refractory countdown.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state        <= ST_INTEGRATE;
            r_sv         <= '0;
            r_leak_cnt   <= '0;
            r_refrac_cnt <= '0;
        end else begin
            case (state)
                ST_INTEGRATE: begin
                    if (i_en) begin
                        r_sv <= new_sv;
                        if (!LEAK_ON || leak_tick) begin
                            r_leak_cnt <= '0;
                        end else begin
                            r_leak_cnt <= r_leak_cnt + LCW'(1);
                        end
                        if (new_sv >= i_threshold) begin
                            state <= ST_FIRE;
                        end
                    end
                end
                ST_FIRE: begin
                    r_sv       <= '0;
                    r_leak_cnt <= '0;
                    if (REFRAC_ON) begin
                        state        <= ST_REFRAC;
                        r_refrac_cnt <= REFRAC_LOAD;
                    end else begin
                        state <= ST_INTEGRATE;
                    end
                end
                ST_REFRAC: begin
                    r_sv <= '0;
                    if (r_refrac_cnt == '0) begin
                        state <= ST_INTEGRATE;
                    end else begin
                        r_refrac_cnt <= r_refrac_cnt - RCW'(1);
                    end
                end
                default: begin
                    state <= ST_INTEGRATE;
                end
            endcase
        end
    end

    // The outputs are decoded directly from registers, so they are glitch-free during the fire cycle.
    always_comb begin
        o_sv         = r_sv;
        o_spike      = (state == ST_FIRE);
        o_refractory = (state == ST_REFRAC);
        o_dbg_state  = state;
    end

endmodule

// File: tb/tb_lif_neuron.sv
// Directed bench for lif_neuron. Three builds share clock, reset and inputs:
// dut_a uses the default parameters (leak period 16, refractory 4), dut_b has the
// leak disabled, and dut_c has the leak disabled and no refractory period.
`timescale 1ns/1ps
module tb_lif_neuron;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [7:0]  syn;
    logic [63:0] w;
    logic [19:0] thr;

    logic [19:0] sv_a, sv_b, sv_c;
    logic        spk_a, spk_b, spk_c;
    logic        ref_a, ref_b, ref_c;
    logic [1:0]  st_a, st_b, st_c;

    logic [19:0] cap_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lif_neuron dut_a (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_syn_spike(syn), .i_weights(w),
        .i_threshold(thr), .o_sv(sv_a), .o_spike(spk_a), .o_refractory(ref_a),
        .o_dbg_state(st_a)
    );

    lif_neuron #(.p_leak_period(0)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_syn_spike(syn), .i_weights(w),
        .i_threshold(thr), .o_sv(sv_b), .o_spike(spk_b), .o_refractory(ref_b),
        .o_dbg_state(st_b)
    );

    lif_neuron #(.p_leak_period(0), .p_refrac(0)) dut_c (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_syn_spike(syn), .i_weights(w),
        .i_threshold(thr), .o_sv(sv_c), .o_spike(spk_c), .o_refractory(ref_c),
        .o_dbg_state(st_c)
    );

    // Model of the downstream last-value register: it captures o_sv shortly after the spike rises.
    always @(posedge spk_b) begin
        #1 cap_b = sv_b;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; syn = '0; w = '0; thr = '1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic set_all_w(input logic [7:0] v);
        for (int k = 0; k < 8; k++) w[k*8 +: 8] = v;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; syn = '0; w = '0; thr = '1;
        #1;
        checks++;
        if ({sv_a, spk_a, ref_a, st_a} !== 23'd0) begin
            errors++; $display("FAIL reset_a got sv=%0d spk=%b ref=%b st=%0d exp all 0", sv_a, spk_a, ref_a, st_a);
        end
        checks++;
        if ({sv_b, spk_b, ref_b, st_b} !== 23'd0) begin
            errors++; $display("FAIL reset_b got sv=%0d spk=%b ref=%b st=%0d exp all 0", sv_b, spk_b, ref_b, st_b);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        set_all_w(8'd50); syn = 8'hFF;
        tick(3);
        checks++;
        if (sv_b !== 20'd0 || st_b !== 2'd0) begin
            errors++; $display("FAIL idle_hold got sv=%0d st=%0d exp sv=0 st=0", sv_b, st_b);
        end
    endtask

    // Steady input of 10 per cycle and threshold 50, leak disabled, refractory period of 4.
    task automatic test_integrate_fire();
        int exp_sv[15]  = '{10, 20, 30, 40, 50, 0, 0, 0, 0, 0, 10, 20, 30, 40, 50};
        bit exp_spk[15] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
        bit exp_ref[15] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0};
        do_reset();
        w[7:0] = 8'd10; syn = 8'h01; thr = 20'd50; en = 1'b1;
        for (int k = 0; k < 15; k++) begin
            tick(1);
            checks++;
            if (sv_b !== 20'(exp_sv[k]) || spk_b !== exp_spk[k] || ref_b !== exp_ref[k]) begin
                errors++;
                $display("FAIL integ_seq[%0d] got sv=%0d spk=%b ref=%b exp sv=%0d spk=%b ref=%b",
                         k, sv_b, spk_b, ref_b, exp_sv[k], exp_spk[k], exp_ref[k]);
            end
            if (k == 4) begin
                @(negedge clk);
                checks++;
                if (sv_b !== 20'd50 || spk_b !== 1'b1 || cap_b !== 20'd50) begin
                    errors++;
                    $display("FAIL spike_stable got sv=%0d spk=%b cap=%0d exp 50 1 50", sv_b, spk_b, cap_b);
                end
            end
        end
    endtask

    // Negative weights clamp at zero; full positive drive reaches the threshold on the second cycle.
    task automatic test_clamp_and_sum();
        do_reset();
        w[7:0] = 8'd100; syn = 8'h01; en = 1'b1;
        tick(1);
        checks++;
        if (sv_b !== 20'd100) begin
            errors++; $display("FAIL load100 got %0d exp 100", sv_b);
        end
        w = '0; w[31:24] = 8'h80; syn = 8'h08;
        tick(1);
        checks++;
        if (sv_b !== 20'd0 || spk_b !== 1'b0) begin
            errors++; $display("FAIL clamp_zero got sv=%0d spk=%b exp 0 0", sv_b, spk_b);
        end
        set_all_w(8'd127); syn = 8'hFF; thr = 20'd2000;
        tick(1);
        checks++;
        if (sv_b !== 20'd1016 || spk_b !== 1'b0) begin
            errors++; $display("FAIL sum_1016 got sv=%0d spk=%b exp 1016 0", sv_b, spk_b);
        end
        tick(1);
        checks++;
        if (sv_b !== 20'd2032 || spk_b !== 1'b1) begin
            errors++; $display("FAIL sum_fire got sv=%0d spk=%b exp 2032 1", sv_b, spk_b);
        end
    endtask

    // The leak fires on the 16th enabled cycle, and disabled cycles push it back.
    task automatic test_leak();
        do_reset();
        set_all_w(8'd100); syn = 8'hFF; en = 1'b1;
        tick(2);
        checks++;
        if (sv_a !== 20'd1600) begin
            errors++; $display("FAIL leak_load got %0d exp 1600", sv_a);
        end
        syn = 8'h00;
        tick(6);
        en = 1'b0;
        tick(10);
        checks++;
        if (sv_a !== 20'd1600) begin
            errors++; $display("FAIL leak_hold_dis got %0d exp 1600", sv_a);
        end
        en = 1'b1;
        tick(7);
        checks++;
        if (sv_a !== 20'd1600) begin
            errors++; $display("FAIL leak_early got %0d exp 1600", sv_a);
        end
        tick(1);
        checks++;
        if (sv_a !== 20'd1500) begin
            errors++; $display("FAIL leak_tick got %0d exp 1500", sv_a);
        end
        tick(15);
        w = '0; w[7:0] = 8'd16; syn = 8'h01;
        tick(1);
        checks++;
        if (sv_a !== 20'd1423) begin
            errors++; $display("FAIL leak_plus_input got %0d exp 1423", sv_a);
        end
    endtask

    // Saturation: with the threshold at the maximum, the neuron fires exactly when it clamps.
    task automatic test_saturation();
        do_reset();
        set_all_w(8'd127); syn = 8'hFF; thr = 20'hFFFFF; en = 1'b1;
        tick(1032);
        checks++;
        if (sv_b !== 20'd1048512 || spk_b !== 1'b0) begin
            errors++; $display("FAIL sat_pre got sv=%0d spk=%b exp 1048512 0", sv_b, spk_b);
        end
        tick(1);
        checks++;
        if (sv_b !== 20'hFFFFF || spk_b !== 1'b1) begin
            errors++; $display("FAIL sat_fire got sv=%h spk=%b exp fffff 1", sv_b, spk_b);
        end
        @(negedge clk);
        checks++;
        if (sv_b !== 20'hFFFFF || cap_b !== 20'hFFFFF) begin
            errors++; $display("FAIL sat_capture got sv=%h cap=%h exp fffff fffff", sv_b, cap_b);
        end
    endtask

    // Asynchronous reset during the fire cycle and during the refractory period.
    task automatic test_reset_abort();
        do_reset();
        w[7:0] = 8'd10; syn = 8'h01; thr = 20'd10; en = 1'b1;
        tick(1);
        checks++;
        if (spk_b !== 1'b1 || sv_b !== 20'd10) begin
            errors++; $display("FAIL abort_pre got spk=%b sv=%0d exp 1 10", spk_b, sv_b);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({sv_b, spk_b, ref_b} !== 22'd0) begin
            errors++; $display("FAIL abort_fire got sv=%0d spk=%b ref=%b exp 0 0 0", sv_b, spk_b, ref_b);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (st_b !== 2'd0) begin
            errors++; $display("FAIL abort_fire_state got %0d exp 0", st_b);
        end
        tick(3);
        checks++;
        if (ref_b !== 1'b1) begin
            errors++; $display("FAIL refrac_entry got %b exp 1", ref_b);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({sv_b, spk_b, ref_b, st_b} !== 24'd0) begin
            errors++; $display("FAIL abort_refrac got sv=%0d spk=%b ref=%b st=%0d exp all 0", sv_b, spk_b, ref_b, st_b);
        end
        rst = 1'b0;
        thr = 20'd50;
        tick(1);
        checks++;
        if (sv_b !== 20'd10 || ref_b !== 1'b0 || st_b !== 2'd0) begin
            errors++; $display("FAIL abort_resume got sv=%0d ref=%b st=%0d exp 10 0 0", sv_b, ref_b, st_b);
        end
    endtask

    // A build with no refractory period can fire every second cycle.
    task automatic test_back_to_back();
        do_reset();
        w[7:0] = 8'd10; syn = 8'h01; thr = 20'd10; en = 1'b1;
        tick(1);
        checks++;
        if (spk_c !== 1'b1 || sv_c !== 20'd10) begin
            errors++; $display("FAIL b2b_fire1 got spk=%b sv=%0d exp 1 10", spk_c, sv_c);
        end
        tick(1);
        checks++;
        if (spk_c !== 1'b0 || sv_c !== 20'd0 || st_c !== 2'd0) begin
            errors++; $display("FAIL b2b_gap got spk=%b sv=%0d st=%0d exp 0 0 0", spk_c, sv_c, st_c);
        end
        tick(1);
        checks++;
        if (spk_c !== 1'b1 || sv_c !== 20'd10) begin
            errors++; $display("FAIL b2b_fire2 got spk=%b sv=%0d exp 1 10", spk_c, sv_c);
        end
    endtask

    initial begin
        test_reset();
        test_integrate_fire();
        test_clamp_and_sum();
        test_leak();
        test_saturation();
        test_reset_abort();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
